// File: rtl/video_frame_sig_if.sv
// Pixel-rate video stream into the frame signer: enable, colour and active-low syncs.
`timescale 1ns/1ps
interface video_frame_sig_if #(
  parameter int COLOR_W = 3
) ();
  logic               clock_en;
  logic [COLOR_W-1:0] VIDEO_R;
  logic [COLOR_W-1:0] VIDEO_G;
  logic [COLOR_W-1:0] VIDEO_B;
  logic               HSYNC_n;
  logic               VSYNC_n;

  modport master (output clock_en, VIDEO_R, VIDEO_G, VIDEO_B, HSYNC_n, VSYNC_n);
  modport slave  (input  clock_en, VIDEO_R, VIDEO_G, VIDEO_B, HSYNC_n, VSYNC_n);
endinterface

// File: rtl/video_frame_sig.sv
// Per-frame CRC-32 signature with line/pixel counting over a run of FRAME_LIMIT frames.
// Optional build macro VFS_SYNC_HASH_EN hashes every capture sample as {R,G,B,HSYNC_n,VSYNC_n}.
`timescale 1ns/1ps
module video_frame_sig #(
  parameter int COLOR_W     = 3,
  parameter int CNT_W       = 10,
  parameter int FRAME_LIMIT = 3
) (
  input  logic               clock,
  input  logic               reset_N,
  video_frame_sig_if.slave   vid,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [31:0]        frame_sig,
  output logic               sig_valid,
  output logic [7:0]         frame_idx,
  output logic [CNT_W-1:0]   line_count,
  output logic [CNT_W-1:0]   pixel_count,
  output logic               overflow
);
`ifdef VFS_SYNC_HASH_EN
  localparam int WORD_W = 3*COLOR_W + 2;
`else
  localparam int WORD_W = 3*COLOR_W;
`endif
  localparam logic [31:0]      CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       LIMIT    = 8'(FRAME_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [31:0]      crc_q, crc_d, frame_sig_q, frame_sig_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] line_count_q, line_count_d, pixel_count_q, pixel_count_d;
  logic [7:0]       frame_idx_q, frame_idx_d, idx_next;
  logic             overflow_q, overflow_d, sig_valid_q, sig_valid_d;
  logic             hs_fall, vs_fall, active, hash_en;
  logic [WORD_W-1:0] word;

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [WORD_W-1:0] w);
    logic [31:0] c;
    c = crc;
    for (int i = WORD_W-1; i >= 0; i--) begin
      if (c[31] ^ w[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign hs_fall  = hs_prev_q & ~vid.HSYNC_n;
  assign vs_fall  = vs_prev_q & ~vid.VSYNC_n;
  assign active   = vid.HSYNC_n & vid.VSYNC_n;
  assign idx_next = frame_idx_q + 8'd1;
`ifdef VFS_SYNC_HASH_EN
  assign word     = {vid.VIDEO_R, vid.VIDEO_G, vid.VIDEO_B, vid.HSYNC_n, vid.VSYNC_n};
  assign hash_en  = 1'b1;
`else
  assign word     = {vid.VIDEO_R, vid.VIDEO_G, vid.VIDEO_B};
  assign hash_en  = active;
`endif

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    crc_d         = crc_q;
    frame_sig_d   = frame_sig_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_count_d  = line_count_q;
    pixel_count_d = pixel_count_q;
    frame_idx_d   = frame_idx_q;
    overflow_d    = overflow_q;
    sig_valid_d   = 1'b0;
    if (vid.clock_en) begin
      hs_prev_d = vid.HSYNC_n;
      vs_prev_d = vid.VSYNC_n;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_WAIT_VS;
            frame_idx_d = 8'd0;
            overflow_d  = 1'b0;
            crc_d       = 32'd0;
          end
        end
        S_WAIT_VS: begin
          if (vs_fall) begin
            state_d    = S_CAPTURE;
            crc_d      = CRC_INIT;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
          end
        end
        S_CAPTURE: begin
          // A coincident HSYNC fall is swallowed by the frame close.
          if (vs_fall) begin
            frame_sig_d  = crc_q;
            line_count_d = line_cnt_q;
            sig_valid_d  = 1'b1;
            frame_idx_d  = idx_next;
            crc_d        = CRC_INIT;
            pix_cnt_d    = '0;
            line_cnt_d   = '0;
            if (idx_next == LIMIT) state_d = S_DONE;
          end else begin
            if (hash_en) crc_d = crc_step(crc_q, word);
            if (active) begin
              if (pix_cnt_q == CNT_MAX) overflow_d = 1'b1;
              else                      pix_cnt_d  = pix_cnt_q + CNT_ONE;
            end
            if (hs_fall) begin
              pixel_count_d = pix_cnt_q;
              pix_cnt_d     = '0;
              if (line_cnt_q == CNT_MAX) overflow_d = 1'b1;
              else                       line_cnt_d = line_cnt_q + CNT_ONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q       <= S_IDLE;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      crc_q         <= 32'd0;
      frame_sig_q   <= 32'd0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_count_q  <= '0;
      pixel_count_q <= '0;
      frame_idx_q   <= 8'd0;
      overflow_q    <= 1'b0;
      sig_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      crc_q         <= crc_d;
      frame_sig_q   <= frame_sig_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_count_q  <= line_count_d;
      pixel_count_q <= pixel_count_d;
      frame_idx_q   <= frame_idx_d;
      overflow_q    <= overflow_d;
      sig_valid_q   <= sig_valid_d;
    end
  end

  assign busy        = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
  assign done        = (state_q == S_DONE);
  assign frame_sig   = frame_sig_q;
  assign sig_valid   = sig_valid_q;
  assign frame_idx   = frame_idx_q;
  assign line_count  = line_count_q;
  assign pixel_count = pixel_count_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_video_frame_sig.sv
// Randomised frame traffic against a frame-level reference model; two DUTs (CNT_W 10 and 3) share the stream.
`timescale 1ns/1ps
module tb_video_frame_sig;
  localparam int          CW    = 3;
  localparam int          LIMIT = 3;
  localparam logic [31:0] POLY  = 32'h04C1_1DB7;

  logic clock = 1'b0;
  logic reset_N = 1'b0;
  logic start = 1'b0;
  always #5 clock = ~clock;

  video_frame_sig_if #(.COLOR_W(CW)) vif ();

  logic        busy, done, sig_valid, overflow;
  logic [31:0] frame_sig;
  logic [7:0]  frame_idx;
  logic [9:0]  line_count, pixel_count;
  logic        s_busy, s_done, s_sig_valid, s_overflow;
  logic [31:0] s_frame_sig;
  logic [7:0]  s_frame_idx;
  logic [2:0]  s_line_count, s_pixel_count;

  video_frame_sig #(.COLOR_W(CW), .CNT_W(10), .FRAME_LIMIT(LIMIT)) u_dut (
    .clock(clock), .reset_N(reset_N), .vid(vif), .start(start),
    .busy(busy), .done(done), .frame_sig(frame_sig), .sig_valid(sig_valid),
    .frame_idx(frame_idx), .line_count(line_count), .pixel_count(pixel_count),
    .overflow(overflow));

  video_frame_sig #(.COLOR_W(CW), .CNT_W(3), .FRAME_LIMIT(LIMIT)) u_dut_s (
    .clock(clock), .reset_N(reset_N), .vid(vif), .start(start),
    .busy(s_busy), .done(s_done), .frame_sig(s_frame_sig), .sig_valid(s_sig_valid),
    .frame_idx(s_frame_idx), .line_count(s_line_count), .pixel_count(s_pixel_count),
    .overflow(s_overflow));

  int n_vec = 0, n_err = 0;
  int sv_cnt = 0, sv_cnt_s = 0;

  // counts every clock sig_valid is seen high, so a stretched pulse shows up as an extra count
  always @(negedge clock) begin
    if (sig_valid === 1'b1)   sv_cnt++;
    if (s_sig_valid === 1'b1) sv_cnt_s++;
  end

  // reference model state
  bit          m_wait, m_capt, m_done, m_ovf_b, m_ovf_s;
  int          m_idx, m_lc_b, m_lc_s, m_pc_b, m_pc_s, m_sv;
  logic [31:0] m_sig;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [3*CW-1:0] w);
    logic [31:0] x;
    x = c ^ {w, {(32-3*CW){1'b0}}};
    for (int i = 0; i < 3*CW; i++) x = x[31] ? ((x << 1) ^ POLY) : (x << 1);
    return x;
  endfunction

  // one enabled sample, then 0..2 disabled cycles carrying junk that must be ignored
  task automatic smp(input logic hs, input logic vs, input logic [CW-1:0] r,
                     input logic [CW-1:0] g, input logic [CW-1:0] b, input logic st);
    @(negedge clock);
    vif.HSYNC_n = hs; vif.VSYNC_n = vs;
    vif.VIDEO_R = r; vif.VIDEO_G = g; vif.VIDEO_B = b;
    vif.clock_en = 1'b1; start = st;
    @(posedge clock); #1;
    vif.clock_en = 1'b0; start = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      vif.HSYNC_n = 1'($urandom); vif.VSYNC_n = 1'($urandom);
      vif.VIDEO_R = CW'($urandom); vif.VIDEO_G = CW'($urandom); vif.VIDEO_B = CW'($urandom);
      start = 1'($urandom);
      @(posedge clock); #1;
      start = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clock); #1;
    check_val({tag, ":sig"},   frame_sig,   m_sig);
    check_val({tag, ":lines"}, 32'(line_count),  m_lc_b);
    check_val({tag, ":pix"},   32'(pixel_count), m_pc_b);
    check_val({tag, ":idx"},   32'(frame_idx),   m_idx);
    check_val({tag, ":ovf"},   32'(overflow),    32'(m_ovf_b));
    check_val({tag, ":busy"},  32'(busy),        32'(m_wait || m_capt));
    check_val({tag, ":done"},  32'(done),        32'(m_done));
    check_val({tag, ":svcnt"}, sv_cnt,           m_sv);
    check_val({tag, ":s_sig"},   s_frame_sig,   m_sig);
    check_val({tag, ":s_lines"}, 32'(s_line_count),  m_lc_s);
    check_val({tag, ":s_pix"},   32'(s_pixel_count), m_pc_s);
    check_val({tag, ":s_ovf"},   32'(s_overflow),    32'(m_ovf_s));
    check_val({tag, ":s_svcnt"}, sv_cnt_s,           m_sv);
  endtask

  task automatic press_start();
    smp(1'b0, 1'b1, '0, '0, '0, 1'b1);
    if (!m_wait && !m_capt) begin
      m_wait = 1; m_done = 0; m_idx = 0; m_ovf_b = 0; m_ovf_s = 0;
    end
  endtask

  task automatic enter_capture();
    smp(1'b0, 1'b0, '0, '0, '0, 1'b0);
    if (m_wait) begin m_wait = 0; m_capt = 1; end
  endtask

  // nlines lines of pixels, each closed by an HSYNC fall unless coinc closes the last with VSYNC
  task automatic run_frame(input int nlines, input bit coinc, input int npix_fix,
                           input bit white, input string tag);
    logic [31:0]   c;
    logic [CW-1:0] r, g, b;
    int            np, falls, last;
    bit            big_px;
    c = 32'hFFFF_FFFF; falls = 0; last = -1; big_px = 0;
    for (int l = 0; l < nlines; l++) begin
      np = (npix_fix > 0) ? npix_fix : int'($urandom_range(1, 9));
      if (np > 7) big_px = 1;
      for (int p = 0; p < np; p++) begin
        r = white ? '1 : CW'($urandom);
        g = white ? '1 : CW'($urandom);
        b = white ? '1 : CW'($urandom);
        c = crc_ref(c, {r, g, b});
        smp(1'b1, 1'b1, r, g, b, 1'b0);
      end
      if (!(coinc && l == nlines-1)) begin
        smp(1'b0, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom), 1'b0);
        falls++; last = np;
      end
    end
    if (!coinc) smp(1'b0, 1'b1, '0, '0, '0, 1'b0);
    smp(1'b0, 1'b0, CW'($urandom), CW'($urandom), CW'($urandom), 1'b0);
    if (m_capt) begin
      m_sig  = c;
      m_lc_b = sat(falls, 10);
      m_lc_s = sat(falls, 3);
      if (last >= 0) begin m_pc_b = sat(last, 10); m_pc_s = sat(last, 3); end
      if (big_px || falls > 7) m_ovf_s = 1;
      m_idx++; m_sv++;
      if (m_idx == LIMIT) begin m_capt = 0; m_done = 1; end
    end
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] sig_keep;

  initial begin
    vif.clock_en = 1'b0; vif.HSYNC_n = 1'b1; vif.VSYNC_n = 1'b1;
    vif.VIDEO_R = '0; vif.VIDEO_G = '0; vif.VIDEO_B = '0;
    m_wait = 0; m_capt = 0; m_done = 0; m_ovf_b = 0; m_ovf_s = 0;
    m_idx = 0; m_lc_b = 0; m_lc_s = 0; m_pc_b = 0; m_pc_s = 0; m_sv = 0; m_sig = 32'd0;

    #23;
    check_all("reset");
    check_val("reset:sig_valid", 32'(sig_valid), 32'd0);
    reset_N = 1'b1;

    // empty frame: two VSYNC falls with nothing active between
    press_start();
    enter_capture();
    run_frame(0, 1'b0, 0, 1'b0, "empty");

    // two identical 4x5 all-ones frames, the second one reaching the frame limit
    run_frame(4, 1'b0, 5, 1'b1, "white1");
    sig_keep = frame_sig;
    run_frame(4, 1'b0, 5, 1'b1, "white2");
    check_val("white_repeat", frame_sig, sig_keep);
    run_frame(3, 1'b0, 0, 1'b0, "in_done");

    // second run: 9-pixel lines saturate the small counter, start while busy, coincident close
    press_start();
    enter_capture();
    run_frame(3, 1'b0, 9, 1'b0, "long_line");
    run_frame(2, 1'b0, 0, 1'b0, "after_ovf");
    press_start();
    check_all("start_busy");
    run_frame(3, 1'b1, 0, 1'b0, "coinc");

    // third run: reset in the middle of a frame
    press_start();
    enter_capture();
    run_frame(2, 1'b0, 0, 1'b0, "pre_rst");
    repeat (3) smp(1'b1, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom), 1'b0);
    @(negedge clock); #2;
    reset_N = 1'b0;
    #1;
    check_val("rst:sig",   frame_sig, 32'd0);
    check_val("rst:idx",   32'(frame_idx), 32'd0);
    check_val("rst:lines", 32'(line_count), 32'd0);
    check_val("rst:pix",   32'(pixel_count), 32'd0);
    check_val("rst:busy",  32'(busy), 32'd0);
    check_val("rst:done",  32'(done), 32'd0);
    check_val("rst:sv",    32'(sig_valid), 32'd0);
    check_val("rst:ovf",   32'(overflow), 32'd0);
    check_val("rst:s_ovf", 32'(s_overflow), 32'd0);
    m_wait = 0; m_capt = 0; m_done = 0; m_ovf_b = 0; m_ovf_s = 0;
    m_idx = 0; m_lc_b = 0; m_lc_s = 0; m_pc_b = 0; m_pc_s = 0; m_sig = 32'd0;
    #20;
    @(negedge clock); #3;
    reset_N = 1'b1;
    check_all("post_rst");

    // randomised runs, including an ignored frame after each run completes
    for (int k = 0; k < 3; k++) begin
      press_start();
      enter_capture();
      for (int f = 0; f < 4; f++)
        run_frame(int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0), 0, 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/video_frame_sig.md
VIDEO_FRAME_SIG -- requirements
Module: video_frame_sig

Interface
REQ-001 SHALL have parameter COLOR_W, default 3: bits per colour channel.
REQ-002 SHALL have parameter CNT_W, default 10: width of the pixel and line counters.
REQ-003 SHALL have parameter FRAME_LIMIT, default 3: number of frames signed per run (1..255).
REQ-004 SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_N  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port clock_en  input  1: pixel-rate enable; a sample is taken only on clock edges where clock_en=1.
REQ-007 SHALL have ports VIDEO_R, VIDEO_G, VIDEO_B  input  COLOR_W each: pixel colour.
REQ-008 SHALL have ports HSYNC_n, VSYNC_n  input  1 each: active-low syncs.
REQ-009 SHALL have port start  input  1: begins a run; honoured only in IDLE or DONE.
REQ-010 SHALL have ports busy and done  output  1 each: high in WAIT_VS/CAPTURE and in DONE respectively.
REQ-011 SHALL have port frame_sig  output  32: CRC of the last completed frame.
REQ-012 SHALL have port sig_valid  output  1: one-clock pulse when frame_sig updates.
REQ-013 SHALL have port frame_idx  output  8: frames completed in the current run.
REQ-014 SHALL have ports line_count and pixel_count  output  CNT_W each: lines in the last frame; active pixels in the last line.
REQ-015 SHALL have port overflow  output  1: sticky, set on counter saturation.

Function
REQ-016 SHALL implement states IDLE, WAIT_VS, CAPTURE, DONE; a start in IDLE/DONE moves to WAIT_VS and clears frame_idx, overflow, and the CRC.
REQ-017 SHALL register the previous HSYNC_n/VSYNC_n per sample (reset value 1); a falling edge is prev=1 and current=0 on a sample.
REQ-018 In WAIT_VS, a VSYNC falling edge SHALL enter CAPTURE with CRC=0xFFFFFFFF and the line/pixel counters at 0.
REQ-019 In CAPTURE, an active sample (HSYNC_n=1, VSYNC_n=1) SHALL advance the CRC by the word {R,G,B} (3*COLOR_W bits).
- CRC-32 poly 0x04C11DB7, fed MSB first, no reflection, no final XOR.
- The pixel counter saturates at 2^CNT_W-1 and sets overflow.
REQ-020 In CAPTURE, an HSYNC falling edge SHALL latch pixel_count from the pixel counter, clear the pixel counter, and increment the line counter (saturating, sets overflow).
REQ-021 In CAPTURE, a VSYNC falling edge SHALL, in a single clock:
- latch frame_sig from the CRC and line_count from the line counter;
- pulse sig_valid and increment frame_idx;
- reinitialise the CRC and both counters.
REQ-022 An HSYNC and VSYNC falling edge on the same sample SHALL be handled as VSYNC only.
REQ-023 When frame_idx reaches FRAME_LIMIT, the FSM SHALL enter DONE on the same edge that increments it; in DONE, samples are ignored and outputs hold.
REQ-024 A start while busy SHALL be ignored.
REQ-025 With clock_en=0, all state except sig_valid (which deasserts) SHALL hold.

Reset
REQ-026 Reset SHALL force IDLE, set busy, done, sig_valid and overflow to 0, and set frame_sig, frame_idx, line_count and pixel_count to 0.
REQ-027 Reset asserted mid-run SHALL abort to IDLE with no sig_valid pulse.

Configuration
REQ-028 With macro VFS_SYNC_HASH_EN defined, the CRC word SHALL be {R,G,B,HSYNC_n,VSYNC_n}, hashed on every CAPTURE sample including blanking.
REQ-029 Without VFS_SYNC_HASH_EN, only active samples SHALL be hashed, with the {R,G,B} word.
REQ-030 The counters and FSM SHALL be identical in both builds.

Verification
REQ-031 Reset, then start, then two VSYNC falls with no active samples between them -> sig_valid once, frame_sig=0xFFFFFFFF, line_count=0, frame_idx=1 (macro undefined).
REQ-032 A frame of 4 lines x 5 active pixels, all RGB=0x7,0x7,0x7 -> line_count=4, pixel_count=5, frame_sig equal to the reference-model CRC; an identical second frame gives an identical frame_sig.
REQ-033 FRAME_LIMIT=3, run 3 frames -> done=1 and busy=0 after the third VSYNC fall; a fourth frame causes no sig_valid and no output change.
REQ-034 Coincident HSYNC/VSYNC fall -> line counter not incremented, frame closed, line_count equals the lines seen before it.
REQ-035 CNT_W=3 with a 9-pixel line -> pixel_count=7, overflow=1 and still 1 after the next frame.
REQ-036 reset_N pulsed low mid-CAPTURE -> all outputs 0 immediately; a start pressed while busy has no effect.
